// File: rtl/mult_4x4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_4x4_pkg
//  Description : Shared types and constants for the sequential 4x4 unsigned
//                multiplier (state encoding, widths, step shift lookup).
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_4x4_pkg;

    // Operand, product and half-operand widths
    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
    localparam int HALF_W = 2;
    localparam int PP_W   = 4;

    // Number of 2x2 partial-product steps and the counter that walks them
    localparam int STEPS = 4;
    localparam int CNT_W = 2;
    localparam int SH_W  = 3;

    // Counter value of the final accumulation step
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Left shift that places the partial product of a given step:
    // step 0 is a0*b0 (weight 1), steps 1 and 2 are the cross terms
    // (weight 4), step 3 is a1*b1 (weight 16).
    function automatic logic [SH_W-1:0] step_shift(input logic [CNT_W-1:0] step);
        logic [SH_W-1:0] sh;
        case (step)
            2'd0:    sh = 3'd0;
            2'd1:    sh = 3'd2;
            2'd2:    sh = 3'd2;
            default: sh = 3'd4;
        endcase
        return sh;
    endfunction

endpackage : mult_4x4_pkg
`default_nettype wire

// File: rtl/mult_4x4_mult2x2.sv
`default_nettype none
// ============================================================================
//  Module      : mult2x2
//  Description : Combinational 2-bit x 2-bit unsigned multiplier producing a
//                4-bit product, built from an AND array and a half-adder row.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult2x2
    import mult_4x4_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    output logic [PP_W-1:0]   p
);

    logic a0b0;
    logic a1b0;
    logic a0b1;
    logic a1b1;
    logic mid_sum;
    logic mid_carry;

    // Partial-product bits and the two half adders that combine them
    always_comb begin
        a0b0      = a[0] & b[0];
        a1b0      = a[1] & b[0];
        a0b1      = a[0] & b[1];
        a1b1      = a[1] & b[1];
        mid_sum   = a1b0 ^ a0b1;
        mid_carry = a1b0 & a0b1;
        p[0]      = a0b0;
        p[1]      = mid_sum;
        p[2]      = a1b1 ^ mid_carry;
        p[3]      = a1b1 & mid_carry;
    end

endmodule : mult2x2
`default_nettype wire

// File: rtl/mult_4x4.sv
`default_nettype none
// ============================================================================
//  Module      : mult_4x4
//  Description : Sequential 4x4 unsigned multiplier. A start pulse captures
//                both operands; four 2x2 partial products are shifted and
//                accumulated on successive clocks, then done_flag is raised
//                and the product is held until the next start.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_4x4
    import mult_4x4_pkg::*;
(
    input  logic              clk,
    input  logic              reset_a,
    input  logic              start,
    input  logic [OP_W-1:0]   dataa,
    input  logic [OP_W-1:0]   datab,
    output logic [PROD_W-1:0] product4x4_out,
    output logic              done_flag
);

    // ------------------------------------------------------------------
    // State and datapath registers with their next-state values
    // ------------------------------------------------------------------
    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic [OP_W-1:0]     a_r;
    logic [OP_W-1:0]     a_nx;
    logic [OP_W-1:0]     b_r;
    logic [OP_W-1:0]     b_nx;
    logic [PROD_W-1:0]   acc;
    logic [PROD_W-1:0]   acc_nx;
    logic                done_r;
    logic                done_nx;

    // Datapath signals
    logic [HALF_W-1:0]   a_half;
    logic [HALF_W-1:0]   b_half;
    logic [PP_W-1:0]     pp;
    logic [PROD_W-1:0]   pp_shifted;
    logic [PROD_W-1:0]   acc_sum;

    // ------------------------------------------------------------------
    // Operand-half select: cnt[0] picks the A half, cnt[1] the B half,
    // giving the order a0*b0, a1*b0, a0*b1, a1*b1.
    // ------------------------------------------------------------------
    always_comb begin
        a_half = cnt[0] ? a_r[OP_W-1:HALF_W] : a_r[HALF_W-1:0];
        b_half = cnt[1] ? b_r[OP_W-1:HALF_W] : b_r[HALF_W-1:0];
    end

    mult2x2 u_mult2x2 (
        .a (a_half),
        .b (b_half),
        .p (pp)
    );

    // Place the partial product at its weight and add it to the accumulator;
    // the full product never exceeds 225, so no carry-out is kept.
    always_comb begin
        pp_shifted = {{(PROD_W-PP_W){1'b0}}, pp} << step_shift(cnt);
        acc_sum    = acc + pp_shifted;
    end

    // ------------------------------------------------------------------
    // Controller state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset_a) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath update decisions; everything holds by default
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        a_nx     = a_r;
        b_nx     = b_r;
        acc_nx   = acc;
        done_nx  = done_r;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_nx     = dataa;
                    b_nx     = datab;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    done_nx  = 1'b0;
                    state_nx = CALC;
                end
            end
            CALC: begin
                // start is deliberately not looked at here
                acc_nx = acc_sum;
                cnt_nx = cnt + CNT_W'(1);
                if (cnt == LAST_STEP) begin
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                acc_nx   = '0;
                done_nx  = 1'b0;
            end
        endcase
    end

    // Datapath registers: operands, step counter, accumulator and done flag
    always_ff @(posedge clk) begin
        if (reset_a) begin
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            done_r <= 1'b0;
        end else begin
            cnt    <= cnt_nx;
            a_r    <= a_nx;
            b_r    <= b_nx;
            acc    <= acc_nx;
            done_r <= done_nx;
        end
    end

    // Outputs come straight from registers
    assign product4x4_out = acc;
    assign done_flag      = done_r;

endmodule : mult_4x4
`default_nettype wire

// File: tb/tb_mult_4x4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_4x4
//  Description : Self-checking bench for mult_4x4 against a plain A*B
//                reference with a fixed four-edge latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_4x4;

    logic       clk;
    logic       reset_a;
    logic       start;
    logic [3:0] dataa;
    logic [3:0] datab;
    logic [7:0] product4x4_out;
    logic       done_flag;

    int checks_total;
    int checks_passed;

    mult_4x4 dut (
        .clk            (clk),
        .reset_a        (reset_a),
        .start          (start),
        .dataa          (dataa),
        .datab          (datab),
        .product4x4_out (product4x4_out),
        .done_flag      (done_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed !== expected) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
        end else begin
            checks_passed++;
        end
    endtask

    // One full multiply: start sampled at edge N, inputs driven and outputs
    // sampled on falling edges. With scramble set, inputs change and start
    // toggles while the operation is in flight; none of it may matter.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         input bit scramble, input int hold);
        logic [7:0] expected;
        expected = 8'(int'(a) * int'(b));
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        @(negedge clk);                      // edge N has passed
        start = 1'b0;
        check("done_low_after_start", done_flag, 1'b0);
        if (scramble) begin
            dataa = 4'($urandom);
            datab = 4'($urandom);
            start = 1'($urandom);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);                  // edge N+k has passed
            if (k < 4) begin
                check("done_early", done_flag, 1'b0);
            end else begin
                check("done_at_n4", done_flag, 1'b1);
                check("product", product4x4_out, expected);
            end
            if (scramble && k < 3) begin
                dataa = 4'($urandom);
                datab = 4'($urandom);
                start = (k == 1) ? 1'b1 : 1'($urandom);
            end else if (scramble && k == 3) begin
                start = 1'($urandom);        // sampled on the last CALC edge
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_done", done_flag, 1'b1);
            check("hold_product", product4x4_out, expected);
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset_a = 1'b1;
        start   = 1'b1;
        dataa   = 4'd9;
        datab   = 4'd9;

        // Reset wins over start
        repeat (2) @(negedge clk);
        check("reset_done", done_flag, 1'b0);
        check("reset_product", product4x4_out, 8'h00);
        reset_a = 1'b0;
        start   = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_no_start_done", done_flag, 1'b0);
        check("idle_no_start_product", product4x4_out, 8'h00);

        // Basic multiplies
        do_op(4'd15, 4'd15, 1'b0, 2);
        do_op(4'd7,  4'd9,  1'b0, 1);
        do_op(4'd0,  4'd13, 1'b0, 1);

        // Operand capture and ignored mid-CALC start
        do_op(4'd3, 4'd5, 1'b1, 2);

        // Reset on the second CALC edge aborts the operation
        @(negedge clk);
        dataa = 4'd12;
        datab = 4'd11;
        start = 1'b1;
        @(negedge clk);                      // edge N
        start = 1'b0;
        @(negedge clk);                      // edge N+1
        reset_a = 1'b1;
        @(negedge clk);                      // edge N+2 with reset
        reset_a = 1'b0;
        check("abort_done", done_flag, 1'b0);
        check("abort_product", product4x4_out, 8'h00);
        repeat (4) @(negedge clk);
        check("abort_no_done", done_flag, 1'b0);
        check("abort_still_zero", product4x4_out, 8'h00);
        do_op(4'd2, 4'd3, 1'b0, 1);

        // Back-to-back with start held high: done after N+4 and N+9 only
        @(negedge clk);
        dataa = 4'd6;
        datab = 4'd6;
        start = 1'b1;
        @(negedge clk);                      // edge N
        dataa = 4'd10;
        datab = 4'd4;
        check("b2b_done_n0", done_flag, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 9) start = 1'b0;
            check("b2b_done_pattern", done_flag, (k == 4 || k == 9) ? 1'b1 : 1'b0);
            if (k == 4) check("b2b_product_first", product4x4_out, 8'h24);
            if (k == 9) check("b2b_product_second", product4x4_out, 8'h28);
        end
        @(negedge clk);
        check("b2b_hold", product4x4_out, 8'h28);

        // Exhaustive sweep, randomly disturbing inputs on about half the ops
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(4'(a), 4'(b), 1'($urandom), int'($urandom_range(0, 2)));
            end
        end

        // Random operations with random idle gaps
        for (int n = 0; n < 40; n++) begin
            do_op(4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_mult_4x4
`default_nettype wire
